// File: rtl/mtr_drv_pkg.sv
// Shared types and defaults for the motor-side PWM driver.
package mtr_drv_pkg;

    localparam int unsigned CNT_W_DEF        = 11;
    localparam int unsigned DEAD_PERIODS_DEF = 2;

    typedef enum logic [1:0] {OFF, FWD, REV, DEAD} mtr_state_t;

    // Start-up decision used from OFF and when a dead interval expires.
    function automatic mtr_state_t launch_state(input logic spd_nz, input logic rev);
        if (!spd_nz) begin
            return OFF;
        end
        return rev ? REV : FWD;
    endfunction

endpackage

// File: rtl/mtr_side_pwm.sv
// One motor: direction FSM with dead periods, period-aligned duty sampling
// and a registered forward/reverse gate pair.
module mtr_side_pwm
    import mtr_drv_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEAD_PERIODS = DEAD_PERIODS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_wrap,
    input  logic             i_pwr_up,
    input  logic [CNT_W-1:0] i_spd,
    input  logic             i_rev,
    output logic             o_pwm_frwrd,
    output logic             o_pwm_rev
);

    localparam int unsigned       DEAD_W    = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PERIODS - 1);

    mtr_state_t        r_state;
    mtr_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_duty;
    logic [CNT_W-1:0]  w_duty_nxt;
    logic              r_dir;
    logic              w_dir_nxt;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic [DEAD_W-1:0] w_dead_cnt_nxt;
    logic              r_pwm_frwrd;
    logic              r_pwm_rev;
    logic              w_drive;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= OFF;
            r_duty     <= '0;
            r_dir      <= 1'b0;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_dir      <= w_dir_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
        end
    end

    // Power loss overrides everything; otherwise all decisions happen at wrap.
    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_dir_nxt      = r_dir;
        w_dead_cnt_nxt = r_dead_cnt;
        if (!i_pwr_up) begin
            w_state_nxt    = OFF;
            w_duty_nxt     = '0;
            w_dead_cnt_nxt = '0;
        end else if (i_wrap) begin
            w_duty_nxt = i_spd;
            w_dir_nxt  = i_rev;
            case (r_state)
                OFF: w_state_nxt = launch_state(i_spd != '0, i_rev);
                FWD, REV: begin
                    if (i_spd == '0) begin
                        w_state_nxt = OFF;
                    end else if (i_rev != (r_state == REV)) begin
                        w_state_nxt    = DEAD;
                        w_dead_cnt_nxt = DEAD_LOAD;
                    end
                end
                DEAD: begin
                    if (r_dead_cnt != '0) begin
                        w_dead_cnt_nxt = r_dead_cnt - DEAD_W'(1);
                    end else begin
                        w_state_nxt = launch_state(i_spd != '0, i_rev);
                    end
                end
                default: w_state_nxt = OFF;
            endcase
        end
    end

    assign w_drive = i_pwr_up && (i_cnt < r_duty);

    // Gates are steered by both state and sampled direction, so they can never overlap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_frwrd <= 1'b0;
            r_pwm_rev   <= 1'b0;
        end else begin
            r_pwm_frwrd <= w_drive && (r_state == FWD) && !r_dir;
            r_pwm_rev   <= w_drive && (r_state == REV) && r_dir;
        end
    end

    assign o_pwm_frwrd = r_pwm_frwrd;
    assign o_pwm_rev   = r_pwm_rev;

endmodule

// File: rtl/mtr_drv_pwm.sv
// Dual H-bridge PWM driver: shared period counter feeding two independent
// per-motor gate generators.
module mtr_drv_pwm
    import mtr_drv_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEAD_PERIODS = DEAD_PERIODS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_up,
    input  logic [CNT_W-1:0] lft_spd,
    input  logic             lft_rev,
    input  logic [CNT_W-1:0] rght_spd,
    input  logic             rght_rev,
    output logic             PWM_frwrd_lft,
    output logic             PWM_rev_lft,
    output logic             PWM_frwrd_rght,
    output logic             PWM_rev_rght,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Period end marker; decoded straight from the counter register.
    assign wrap = (r_cnt == '1);

    mtr_side_pwm #(
        .CNT_W        (CNT_W),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_lft (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cnt       (r_cnt),
        .i_wrap      (wrap),
        .i_pwr_up    (pwr_up),
        .i_spd       (lft_spd),
        .i_rev       (lft_rev),
        .o_pwm_frwrd (PWM_frwrd_lft),
        .o_pwm_rev   (PWM_rev_lft)
    );

    mtr_side_pwm #(
        .CNT_W        (CNT_W),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_rght (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cnt       (r_cnt),
        .i_wrap      (wrap),
        .i_pwr_up    (pwr_up),
        .i_spd       (rght_spd),
        .i_rev       (rght_rev),
        .o_pwm_frwrd (PWM_frwrd_rght),
        .o_pwm_rev   (PWM_rev_rght)
    );

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Scoreboard bench for mtr_drv_pwm: per-period high-cycle counts of all four
// gates are queued by the stimulus and checked by an independent monitor.
module tb_mtr_drv_pwm;

    localparam int unsigned CNT_W = 11;

    logic             clk;
    logic             rst_n;
    logic             pwr_up;
    logic [CNT_W-1:0] lft_spd;
    logic             lft_rev;
    logic [CNT_W-1:0] rght_spd;
    logic             rght_rev;
    logic             PWM_frwrd_lft;
    logic             PWM_rev_lft;
    logic             PWM_frwrd_rght;
    logic             PWM_rev_rght;
    logic             wrap;

    mtr_drv_pwm #(.CNT_W(CNT_W), .DEAD_PERIODS(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwr_up         (pwr_up),
        .lft_spd        (lft_spd),
        .lft_rev        (lft_rev),
        .rght_spd       (rght_spd),
        .rght_rev       (rght_rev),
        .PWM_frwrd_lft  (PWM_frwrd_lft),
        .PWM_rev_lft    (PWM_rev_lft),
        .PWM_frwrd_rght (PWM_frwrd_rght),
        .PWM_rev_rght   (PWM_rev_rght),
        .wrap           (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lf;
        int lr;
        int rf;
        int rr;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Monitor: a window holds the gate outputs for cnt 0..2047 of one period,
    // i.e. the samples seen from cnt=1 up to and including the next cnt=0.
    int acc_lf, acc_lr, acc_rf, acc_rr;
    int win_id  = 0;
    bit wrap_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        chk("invariant_lft", ((PWM_frwrd_lft & PWM_rev_lft) === 1'b1) ? 1 : 0, 0);
        chk("invariant_rght", ((PWM_frwrd_rght & PWM_rev_rght) === 1'b1) ? 1 : 0, 0);
        if (mon_en) begin
            acc_lf += int'(PWM_frwrd_lft);
            acc_lr += int'(PWM_rev_lft);
            acc_rf += int'(PWM_frwrd_rght);
            acc_rr += int'(PWM_rev_rght);
            if (wrap_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL win%0d: window closed with no expected entry", win_id);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("win%0d_frwrd_lft", win_id), acc_lf, e.lf);
                    chk($sformatf("win%0d_rev_lft", win_id), acc_lr, e.lr);
                    chk($sformatf("win%0d_frwrd_rght", win_id), acc_rf, e.rf);
                    chk($sformatf("win%0d_rev_rght", win_id), acc_rr, e.rr);
                end
                win_id++;
                acc_lf = 0; acc_lr = 0; acc_rf = 0; acc_rr = 0;
            end
        end else begin
            acc_lf = 0; acc_lr = 0; acc_rf = 0; acc_rr = 0;
        end
        wrap_prev = (wrap === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the caller on the negedge where wrap is high (cnt=2047).
    task automatic wait_wrap();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wrap !== 1'b1 && n < 2100);
        if (wrap !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wrap_timeout: no wrap within %0d cycles", n);
            finish_run();
        end
    endtask

    task automatic push(input int lf, input int lr, input int rf, input int rr);
        exp_t e;
        e.lf = lf; e.lr = lr; e.rf = rf; e.rr = rr;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        wait_wrap();
        tick(2);
        chk("sb_drained", sb_q.size(), 0);
        mon_en = 1'b0;
    endtask

    task automatic chk_gates_zero(input string tag);
        chk({tag, "_frwrd_lft"}, int'(PWM_frwrd_lft), 0);
        chk({tag, "_rev_lft"}, int'(PWM_rev_lft), 0);
        chk({tag, "_frwrd_rght"}, int'(PWM_frwrd_rght), 0);
        chk({tag, "_rev_rght"}, int'(PWM_rev_rght), 0);
    endtask

    initial begin
        #1_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        int n;
        int hi;
        rst_n = 1'b0; pwr_up = 1'b0;
        lft_spd = '0; lft_rev = 1'b0; rght_spd = '0; rght_rev = 1'b0;
        tick(3);
        chk_gates_zero("reset");
        chk("reset_wrap", int'(wrap), 0);

        // Forward 512 / 1024 after the first wrap
        rst_n = 1'b1; pwr_up = 1'b1;
        lft_spd = 11'd512; rght_spd = 11'd1024;
        wait_wrap();
        push(0, 0, 0, 0);
        mon_en = 1'b1;
        push(512, 0, 1024, 0);
        wait_wrap();
        push(512, 0, 1024, 0);

        // Mid-period change is deferred to the next period
        tick(301);
        lft_spd = 11'd1500;
        wait_wrap();
        push(1500, 0, 1024, 0);

        // Reversal with two dead periods, right side untouched
        wait_wrap();
        lft_spd = 11'd800;
        push(800, 0, 1024, 0);
        wait_wrap();
        lft_rev = 1'b1;
        push(0, 0, 1024, 0);
        wait_wrap();
        push(0, 0, 1024, 0);
        wait_wrap();
        push(0, 800, 1024, 0);

        // Power drop at cnt=100, restore at cnt=200 with forward request
        wait_wrap();
        push(0, 100, 100, 0);
        tick(101);
        pwr_up = 1'b0;
        tick(1);
        chk_gates_zero("pwr_drop");
        tick(99);
        pwr_up = 1'b1;
        lft_rev = 1'b0;
        wait_wrap();
        push(800, 0, 1024, 0);

        // Extremes: 0 and 2047, OFF->REV without dead time
        wait_wrap();
        lft_spd = 11'd0; rght_spd = 11'd2047;
        push(0, 0, 2047, 0);
        wait_wrap();
        lft_spd = 11'd2047; lft_rev = 1'b1; rght_spd = 11'd0;
        push(0, 2047, 0, 0);
        drain();

        // Random run; overlap invariant checked every cycle by the monitor
        for (int i = 0; i < 40; i++) begin
            lft_spd  = CNT_W'($urandom_range(0, 2047));
            rght_spd = CNT_W'($urandom_range(0, 2047));
            lft_rev  = 1'($urandom_range(0, 1));
            rght_rev = 1'($urandom_range(0, 1));
            pwr_up   = ($urandom_range(0, 7) != 0);
            tick(int'($urandom_range(1, 1000)));
        end

        // Reset at cnt=900 while left is forward
        pwr_up = 1'b1;
        lft_spd = 11'd1500; lft_rev = 1'b0;
        rght_spd = 11'd300; rght_rev = 1'b1;
        repeat (4) wait_wrap();
        tick(901);
        chk("pre_reset_frwrd_lft", int'(PWM_frwrd_lft), 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_gates_zero("mid_reset");
        chk("mid_reset_wrap", int'(wrap), 0);
        n = 0;
        hi = 0;
        while (wrap !== 1'b1 && n < 3000) begin
            tick(1);
            n++;
            hi += int'(PWM_frwrd_lft) + int'(PWM_rev_lft);
        end
        chk("cnt_restart_to_wrap", n, 2047);
        chk("off_after_reset_lft_highs", hi, 0);
        push(0, 0, 0, 0);
        mon_en = 1'b1;
        push(1500, 0, 0, 300);
        drain();

        finish_run();
    end

endmodule
